// File: rtl/rab_inv_walker.sv
// rab_inv_walker: invalidation sequencer for the RAB translation tables.
// Accepts an inclusive VA range, walks every L1 slice one per cycle and
// clears the slices whose range overlaps it, then (optionally) walks every
// L2 TLB entry through a two-stage read/check pipeline and clears the
// overlapping valid entries. Busy_SO is high for the whole walk.
// Optional feature macro: RAB_INV_L2_EN enables the L2 walk. When it is
// undefined the L1 walk goes straight to DONE and all L2 outputs are 0.
module rab_inv_walker #(
    parameter int unsigned AW               = 32,
    parameter int unsigned N_SLICES         = 16,
    parameter int unsigned L2_N_SETS        = 32,
    parameter int unsigned L2_N_SET_ENTRIES = 32,
    parameter int unsigned PGW              = 12,
    localparam int unsigned L1W = (N_SLICES > 1) ? $clog2(N_SLICES) : 1,
    localparam int unsigned SW  = (L2_N_SETS > 1) ? $clog2(L2_N_SETS) : 1,
    localparam int unsigned EW  = (L2_N_SET_ENTRIES > 1) ? $clog2(L2_N_SET_ENTRIES) : 1
) (
    input  logic              Clk_CI,
    input  logic              Rst_RBI,
    input  logic              InvReq_SI,
    output logic              InvReady_SO,
    input  logic [AW-1:0]     InvAddrMin_DI,
    input  logic [AW-1:0]     InvAddrMax_DI,
    output logic              Busy_SO,
    output logic              Done_SO,
    output logic [L1W-1:0]    L1Idx_SO,
    input  logic [AW-1:0]     L1AddrMin_DI,
    input  logic [AW-1:0]     L1AddrMax_DI,
    input  logic              L1En_DI,
    output logic              L1Clr_SO,
    output logic              L2Rd_SO,
    output logic [SW-1:0]     L2SetIdx_SO,
    output logic [EW-1:0]     L2EntryIdx_SO,
    input  logic [AW-PGW-1:0] L2Vpn_DI,
    input  logic              L2Valid_DI,
    output logic [SW-1:0]     L2ClrSet_SO,
    output logic [EW-1:0]     L2ClrEntry_SO,
    output logic              L2Clr_SO
);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_L1_WALK,
`ifdef RAB_INV_L2_EN
        ST_L2_WALK,
        ST_L2_DRAIN,
`endif
        ST_DONE
    } state_t;

    localparam logic [L1W-1:0] L1_LAST = L1W'(N_SLICES - 1);

    state_t         r_state;
    logic [AW-1:0]  r_min;
    logic [AW-1:0]  r_max;
    logic [L1W-1:0] r_l1_idx;
    logic           r_ready;
    logic           r_busy;
    logic           r_done;
    logic           w_l1_hit;

`ifdef RAB_INV_L2_EN
    localparam int unsigned SB = $clog2(L2_N_SETS);
    localparam int unsigned EB = $clog2(L2_N_SET_ENTRIES);
    localparam int unsigned KW = ((SB + EB) > 0) ? (SB + EB) : 1;
    localparam logic [KW-1:0] K_LAST = KW'(L2_N_SETS * L2_N_SET_ENTRIES - 1);

    logic [KW-1:0] r_k;          // linear index of the entry being read
    logic          r_l2_rd;      // read issued this cycle
    logic          r_l2_chk;     // read data of the previous cycle is on L2Vpn/L2Valid
    logic [SW-1:0] r_clr_set;    // set/entry of the entry whose data is being checked
    logic [EW-1:0] r_clr_ent;
    logic [SW-1:0] w_set;
    logic [EW-1:0] w_ent;
    logic [AW-1:0] w_pg_base;
    logic [AW-1:0] w_pg_end;

    assign w_set = SW'(r_k >> EB);
    assign w_ent = EW'(r_k & KW'(L2_N_SET_ENTRIES - 1));
`endif

    // Walk FSM: range latch, slice/entry counters and registered status outputs.
    always_ff @(posedge Clk_CI) begin
        if (!Rst_RBI) begin
            // NOTE: non-blocking assignments so every register updates from pre-edge values.
            r_state  <= ST_IDLE;
            r_min    <= '0;
            r_max    <= '0;
            r_l1_idx <= '0;
            r_ready  <= 1'b1;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
`ifdef RAB_INV_L2_EN
            r_k       <= '0;
            r_l2_rd   <= 1'b0;
            r_l2_chk  <= 1'b0;
            r_clr_set <= '0;
            r_clr_ent <= '0;
`endif
        end else begin
            r_done <= 1'b0;
`ifdef RAB_INV_L2_EN
            // The check stage trails the read stage by exactly one cycle.
            r_l2_chk <= r_l2_rd;
            if (r_l2_rd) begin
                r_clr_set <= w_set;
                r_clr_ent <= w_ent;
            end
`endif
            case (r_state)
                ST_IDLE: begin
                    if (InvReq_SI) begin
                        r_min    <= InvAddrMin_DI;
                        r_max    <= InvAddrMax_DI;
                        r_l1_idx <= '0;
`ifdef RAB_INV_L2_EN
                        r_k      <= '0;
`endif
                        r_ready  <= 1'b0;
                        r_busy   <= 1'b1;
                        r_state  <= ST_L1_WALK;
                    end
                end
                ST_L1_WALK: begin
                    if (r_l1_idx == L1_LAST) begin
`ifdef RAB_INV_L2_EN
                        r_l2_rd <= 1'b1;
                        r_state <= ST_L2_WALK;
`else
                        r_done  <= 1'b1;
                        r_state <= ST_DONE;
`endif
                    end else begin
                        r_l1_idx <= r_l1_idx + L1W'(1);
                    end
                end
`ifdef RAB_INV_L2_EN
                ST_L2_WALK: begin
                    if (r_k == K_LAST) begin
                        r_l2_rd <= 1'b0;
                        r_state <= ST_L2_DRAIN;
                    end else begin
                        r_k <= r_k + KW'(1);
                    end
                end
                ST_L2_DRAIN: begin
                    r_done  <= 1'b1;
                    r_state <= ST_DONE;
                end
`endif
                ST_DONE: begin
                    r_ready <= 1'b1;
                    r_busy  <= 1'b0;
                    r_state <= ST_IDLE;
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign InvReady_SO = r_ready;
    assign Busy_SO     = r_busy;
    assign Done_SO     = r_done;
    assign L1Idx_SO    = r_l1_idx;

    // Clear strobes are gated by reset so a walk aborted by reset clears
    // nothing at the edge where the reset is sampled.
    assign w_l1_hit = (L1AddrMin_DI <= r_max) && (L1AddrMax_DI >= r_min);
    assign L1Clr_SO = Rst_RBI && (r_state == ST_L1_WALK) && L1En_DI && w_l1_hit;

`ifdef RAB_INV_L2_EN
    // A page never wraps: its end is the base with all offset bits set.
    assign w_pg_base     = {L2Vpn_DI, {PGW{1'b0}}};
    assign w_pg_end      = {L2Vpn_DI, {PGW{1'b1}}};
    assign L2Rd_SO       = r_l2_rd;
    assign L2SetIdx_SO   = w_set;
    assign L2EntryIdx_SO = w_ent;
    assign L2ClrSet_SO   = r_clr_set;
    assign L2ClrEntry_SO = r_clr_ent;
    assign L2Clr_SO      = Rst_RBI && r_l2_chk && L2Valid_DI &&
                           (w_pg_base <= r_max) && (w_pg_end >= r_min);
`else
    logic w_unused_l2;
    assign w_unused_l2   = ^{L2Vpn_DI, L2Valid_DI};
    assign L2Rd_SO       = 1'b0;
    assign L2SetIdx_SO   = '0;
    assign L2EntryIdx_SO = '0;
    assign L2ClrSet_SO   = '0;
    assign L2ClrEntry_SO = '0;
    assign L2Clr_SO      = 1'b0;
`endif

endmodule
